// File: rtl/gowin_dpb.sv
// True dual-port synchronous RAM used as the video card's frame/text buffer.
// Port A is the CPU side, port B the pixel-fetch side; both read and write on one clock.
module gowin_dpb #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 40960,
   parameter int READ_MODE  = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [ADDR_WIDTH-1:0] ada,
   input  logic [DATA_WIDTH-1:0] dina,
   input  logic                  wrea,
   input  logic                  cea,
   input  logic                  ocea,
   input  logic                  reseta,
   output logic [DATA_WIDTH-1:0] douta,
   input  logic [ADDR_WIDTH-1:0] adb,
   input  logic [DATA_WIDTH-1:0] dinb,
   input  logic                  wreb,
   input  logic                  ceb,
   input  logic                  oceb,
   input  logic                  resetb,
   output logic [DATA_WIDTH-1:0] doutb
);

   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   logic                  a_ok;
   logic                  b_ok;
   logic [DATA_WIDTH-1:0] a_rd;
   logic [DATA_WIDTH-1:0] b_rd;
   logic [DATA_WIDTH-1:0] a_q1;
   logic [DATA_WIDTH-1:0] a_q2;
   logic [DATA_WIDTH-1:0] b_q1;
   logic [DATA_WIDTH-1:0] b_q2;

   assign a_ok = {1'b0, ada} < DEPTH_LIM;
   assign b_ok = {1'b0, adb} < DEPTH_LIM;

   // Writes show their own data (write-through); out-of-range reads return zero.
   always_comb begin
      a_rd = '0;
      if (wrea)
         a_rd = dina;
      else if (a_ok)
         a_rd = mem[ada];
   end

   always_comb begin
      b_rd = '0;
      if (wreb)
         b_rd = dinb;
      else if (b_ok)
         b_rd = mem[adb];
   end

   // Port A is written last so it wins a same-address dual write.
   always_ff @(posedge clk) begin
      if (ceb && wreb && b_ok)
         mem[adb] <= dinb;
      if (cea && wrea && a_ok)
         mem[ada] <= dina;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         a_q1 <= '0;
      else if (cea)
         a_q1 <= reseta ? '0 : a_rd;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         a_q2 <= '0;
      else if (cea && reseta)
         a_q2 <= '0;
      else if (ocea)
         a_q2 <= a_q1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         b_q1 <= '0;
      else if (ceb)
         b_q1 <= resetb ? '0 : b_rd;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         b_q2 <= '0;
      else if (ceb && resetb)
         b_q2 <= '0;
      else if (oceb)
         b_q2 <= b_q1;
   end

   assign douta = (READ_MODE != 0) ? a_q2 : a_q1;
   assign doutb = (READ_MODE != 0) ? b_q2 : b_q1;

endmodule

// File: tb/tb_gowin_dpb.sv
// Bench for gowin_dpb: bypass instance checked by table, hand sequences and a random
// run against a memory model; a pipeline instance shares the inputs for latency checks.
module tb_gowin_dpb;

   localparam int DEPTH = 40960;

   typedef struct {
      logic [15:0] ada;
      logic [7:0]  dina;
      logic        wea;
      logic        cea;
      logic        rsta;
      logic [15:0] adb;
      logic [7:0]  dinb;
      logic        web;
      logic        ceb;
      logic        rstb;
      logic        oce;
      logic [7:0]  expa;
      logic [7:0]  expb;
   } vec_t;

   logic        clk;
   logic        resetn;
   logic [15:0] ada;
   logic [7:0]  dina;
   logic        wrea;
   logic        cea;
   logic        ocea;
   logic        reseta;
   logic [15:0] adb;
   logic [7:0]  dinb;
   logic        wreb;
   logic        ceb;
   logic        oceb;
   logic        resetb;
   logic [7:0]  douta;
   logic [7:0]  doutb;
   logic [7:0]  douta_p;
   logic [7:0]  doutb_p;

   int total = 0;
   int bad = 0;

   logic [7:0] mem_m [0:65535] = '{default: 8'h00};
   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;

   int pool [9] = '{0, 1, 2, 5, 100, 38399, 38400, 40960, 65535};

   vec_t tbl [16];

   gowin_dpb #(.READ_MODE(0)) dut (
      .clk(clk), .resetn(resetn),
      .ada(ada), .dina(dina), .wrea(wrea), .cea(cea), .ocea(ocea), .reseta(reseta), .douta(douta),
      .adb(adb), .dinb(dinb), .wreb(wreb), .ceb(ceb), .oceb(oceb), .resetb(resetb), .doutb(doutb)
   );

   gowin_dpb #(.READ_MODE(1)) dut_p (
      .clk(clk), .resetn(resetn),
      .ada(ada), .dina(dina), .wrea(wrea), .cea(cea), .ocea(ocea), .reseta(reseta), .douta(douta_p),
      .adb(adb), .dinb(dinb), .wreb(wreb), .ceb(ceb), .oceb(oceb), .resetb(resetb), .doutb(doutb_p)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: reads see the memory before this edge's writes, A's write lands last.
   task automatic modelStep(input vec_t v);
      logic [7:0] ra;
      logic [7:0] rb;
      ra = v.wea ? v.dina : ((int'(v.ada) < DEPTH) ? mem_m[v.ada] : 8'h00);
      rb = v.web ? v.dinb : ((int'(v.adb) < DEPTH) ? mem_m[v.adb] : 8'h00);
      if (v.cea) m_a = v.rsta ? 8'h00 : ra;
      if (v.ceb) m_b = v.rstb ? 8'h00 : rb;
      if (v.ceb && v.web && int'(v.adb) < DEPTH) mem_m[v.adb] = v.dinb;
      if (v.cea && v.wea && int'(v.ada) < DEPTH) mem_m[v.ada] = v.dina;
   endtask

   task automatic applyStimulus(input vec_t v);
      ada = v.ada; dina = v.dina; wrea = v.wea; cea = v.cea; reseta = v.rsta;
      adb = v.adb; dinb = v.dinb; wreb = v.web; ceb = v.ceb; resetb = v.rstb;
      ocea = v.oce; oceb = v.oce;
      @(posedge clk);
      modelStep(v);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] a_ad, input logic [7:0] a_d, input logic a_we,
                               input logic a_ce, input logic a_rst, input logic [15:0] b_ad,
                               input logic [7:0] b_d, input logic b_we, input logic b_ce,
                               input logic b_rst, input logic oce, input logic [7:0] ea,
                               input logic [7:0] eb);
      vec_t v;
      v.ada = a_ad; v.dina = a_d; v.wea = a_we; v.cea = a_ce; v.rsta = a_rst;
      v.adb = b_ad; v.dinb = b_d; v.web = b_we; v.ceb = b_ce; v.rstb = b_rst;
      v.oce = oce; v.expa = ea; v.expb = eb;
      return v;
   endfunction

   initial begin
      vec_t v;
      tbl[0]  = mk(16'd0,     8'hA5, 1, 1, 0, 16'd0,     8'h00, 0, 1, 0, 1, 8'hA5, 8'h00);
      tbl[1]  = mk(16'd0,     8'h00, 0, 1, 0, 16'd0,     8'h00, 0, 0, 0, 1, 8'hA5, 8'h00);
      tbl[2]  = mk(16'd38399, 8'h3C, 1, 1, 0, 16'd0,     8'h00, 0, 1, 0, 1, 8'h3C, 8'hA5);
      tbl[3]  = mk(16'd0,     8'h00, 0, 0, 0, 16'd38399, 8'h00, 0, 1, 0, 1, 8'h3C, 8'h3C);
      tbl[4]  = mk(16'd100,   8'h11, 1, 1, 0, 16'd100,   8'h00, 0, 1, 0, 1, 8'h11, 8'h00);
      tbl[5]  = mk(16'd100,   8'h00, 0, 1, 0, 16'd100,   8'h00, 0, 1, 0, 1, 8'h11, 8'h11);
      tbl[6]  = mk(16'd100,   8'h22, 1, 1, 0, 16'd100,   8'h33, 1, 1, 0, 1, 8'h22, 8'h33);
      tbl[7]  = mk(16'd100,   8'h00, 0, 1, 0, 16'd100,   8'h00, 0, 1, 0, 1, 8'h22, 8'h22);
      tbl[8]  = mk(16'd5,     8'h77, 1, 0, 0, 16'd5,     8'h00, 0, 1, 0, 1, 8'h22, 8'h00);
      tbl[9]  = mk(16'd5,     8'h00, 0, 1, 0, 16'd0,     8'h00, 0, 0, 0, 1, 8'h00, 8'h00);
      tbl[10] = mk(16'd38400, 8'h5A, 1, 1, 0, 16'hFFFF,  8'h00, 0, 1, 0, 1, 8'h5A, 8'h00);
      tbl[11] = mk(16'hFFFF,  8'hFF, 1, 1, 0, 16'd38400, 8'h00, 0, 1, 0, 1, 8'hFF, 8'h5A);
      tbl[12] = mk(16'hFFFF,  8'h00, 0, 1, 0, 16'd38400, 8'h00, 0, 1, 0, 1, 8'h00, 8'h5A);
      tbl[13] = mk(16'd1,     8'h66, 1, 1, 1, 16'd38400, 8'h00, 0, 1, 1, 1, 8'h00, 8'h00);
      tbl[14] = mk(16'd1,     8'h00, 0, 1, 0, 16'd1,     8'h00, 0, 1, 0, 1, 8'h66, 8'h66);
      tbl[15] = mk(16'd1,     8'h00, 0, 1, 1, 16'd0,     8'h00, 0, 1, 0, 1, 8'h00, 8'hA5);

      resetn = 1'b0;
      ada = '0; dina = '0; wrea = 0; cea = 0; ocea = 0; reseta = 0;
      adb = '0; dinb = '0; wreb = 0; ceb = 0; oceb = 0; resetb = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_douta", douta, 8'h00);
      checkOutput("reset_doutb", doutb, 8'h00);
      checkOutput("reset_douta_p", douta_p, 8'h00);
      checkOutput("reset_doutb_p", doutb_p, 8'h00);
      @(negedge clk);
      resetn = 1'b1;

      // Put known zeros into every address the bench touches.
      foreach (pool[i])
         applyStimulus(mk(16'(pool[i]), 8'h00, 1, 1, 0, 16'd0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));

      for (int i = 0; i < 16; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("tbl%0d_douta", i), douta, tbl[i].expa);
         checkOutput($sformatf("tbl%0d_doutb", i), doutb, tbl[i].expb);
      end

      // Pipeline latency and oce freeze on the READ_MODE=1 instance.
      applyStimulus(mk(16'hFFFF, 8'h00, 0, 1, 0, 16'd0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
      applyStimulus(mk(16'hFFFF, 8'h00, 0, 1, 0, 16'd0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
      checkOutput("pipe_flush", douta_p, 8'h00);
      applyStimulus(mk(16'd38400, 8'h00, 0, 1, 0, 16'd0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
      checkOutput("pipe_lat1", douta_p, 8'h00);
      applyStimulus(mk(16'd38400, 8'h00, 0, 1, 0, 16'd0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
      checkOutput("pipe_lat2", douta_p, 8'h5A);
      applyStimulus(mk(16'd0, 8'h00, 0, 1, 0, 16'd0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
      checkOutput("pipe_freeze1", douta_p, 8'h5A);
      applyStimulus(mk(16'd0, 8'h00, 0, 1, 0, 16'd0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
      checkOutput("pipe_freeze2", douta_p, 8'h5A);
      applyStimulus(mk(16'd0, 8'h00, 0, 1, 0, 16'd0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00));
      checkOutput("pipe_release", douta_p, 8'hA5);

      for (int n = 0; n < 300; n++) begin
         v.ada  = 16'(pool[$urandom_range(0, 8)]);
         v.dina = 8'($urandom);
         v.wea  = 1'($urandom);
         v.cea  = ($urandom_range(0, 9) != 0);
         v.rsta = ($urandom_range(0, 15) == 0);
         v.adb  = 16'(pool[$urandom_range(0, 8)]);
         v.dinb = 8'($urandom);
         v.web  = 1'($urandom);
         v.ceb  = ($urandom_range(0, 9) != 0);
         v.rstb = ($urandom_range(0, 15) == 0);
         v.oce  = 1'b1;
         applyStimulus(v);
         checkOutput($sformatf("rnd%0d_douta", n), douta, m_a);
         checkOutput($sformatf("rnd%0d_doutb", n), doutb, m_b);
      end

      // Async reset mid-cycle clears outputs without a clock edge; memory survives.
      cea = 0; ceb = 0;
      #2;
      resetn = 1'b0;
      m_a = 8'h00; m_b = 8'h00;
      #1;
      checkOutput("async_douta", douta, 8'h00);
      checkOutput("async_doutb", doutb, 8'h00);
      checkOutput("async_douta_p", douta_p, 8'h00);
      checkOutput("async_doutb_p", doutb_p, 8'h00);
      @(posedge clk);
      #3;
      resetn = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(mk(16'(pool[i]), 8'h00, 0, 1, 0, 16'(pool[8 - i]), 8'h00, 0, 1, 0, 1,
                          8'h00, 8'h00));
         checkOutput($sformatf("post_rst%0d_douta", i), douta, m_a);
         checkOutput($sformatf("post_rst%0d_doutb", i), doutb, m_b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
